led_pattern_ctrl: RTL and testbench

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pattern_ctrl.sv | 145 ++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// led_pattern_ctrl
//
// Drives an 8-LED bar from the position of an upstream mod-8 down counter.
// A debounced push-button steps the display mode through
// SINGLE -> INVERT -> FILL -> BLINK -> SINGLE. In BLINK mode the whole bar
// toggles on every counter wrap (0 -> 7). A pause input freezes the LED
// output while everything else keeps running.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   count_in    [2:0] counter position, synchronous to clk
//   mode_btn    raw, bouncing push-button (1 = pressed)
//   pause       1 = hold the current LED value
//   led         [7:0] registered LED drive (1 = lit)
//   mode        [1:0] registered display mode
//   step_pulse  one-cycle strobe in the cycle after count_in changed
// ---------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] count_in,
    input  logic       mode_btn,
    input  logic       pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       step_pulse
);

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_INVERT = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync_reg;
    logic        btn_db_reg;
    logic        btn_db_next;
    logic        btn_db_d_reg;
    logic [15:0] db_cnt_reg;
    logic [15:0] db_cnt_next;
    logic [1:0]  mode_reg;
    logic [2:0]  count_prev_reg;
    logic        step_pulse_reg;
    logic        blink_phase_reg;
    logic [7:0]  led_reg;
    logic [7:0]  led_next;
    logic [7:0]  single_pat;
    logic [7:0]  fill_pat;
    logic        btn_rise;
    logic        wrap;

    // Two-flop synchronizer; sync_reg[1] is the only button copy used below.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], mode_btn};
        end
    end

    // The counter runs only while the synchronized level disagrees with the
    // accepted level; any agreeing cycle drops it back to zero, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing clocks flips btn_db.
    always_comb begin
        btn_db_next = btn_db_reg;
        db_cnt_next = 16'd0;
        if (sync_reg[1] != btn_db_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                btn_db_next = sync_reg[1];
            end else begin
                db_cnt_next = db_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db_reg   <= 1'b0;
            btn_db_d_reg <= 1'b0;
            db_cnt_reg   <= 16'd0;
        end else begin
            btn_db_reg   <= btn_db_next;
            btn_db_d_reg <= btn_db_reg;
            db_cnt_reg   <= db_cnt_next;
        end
    end

    assign btn_rise = btn_db_reg & ~btn_db_d_reg;

    // Counter wrap: previous position 0, current position 7.
    assign wrap = (count_prev_reg == 3'd0) && (count_in == 3'd7);

    // Per-bit pattern terms for the one-hot and fill displays.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pat
            assign single_pat[gi] = (count_in == 3'(gi));
            assign fill_pat[gi]   = (3'(gi) >= count_in);
        end
    endgenerate

    // led is built from the mode/blink_phase values present before this
    // edge, so a mode change shows up one edge after the mode register moves.
    always_comb begin
        led_next = led_reg;
        if (!pause) begin
            case (mode_reg)
                MODE_SINGLE: led_next = single_pat;
                MODE_INVERT: led_next = ~single_pat;
                MODE_FILL:   led_next = fill_pat;
                MODE_BLINK:  led_next = blink_phase_reg ? 8'hFF : 8'h00;
                default:     led_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg        <= MODE_SINGLE;
            count_prev_reg  <= 3'd0;
            step_pulse_reg  <= 1'b0;
            blink_phase_reg <= 1'b0;
            led_reg         <= 8'h00;
        end else begin
            if (btn_rise) begin
                mode_reg <= mode_reg + 2'd1;
            end
            count_prev_reg <= count_in;
            step_pulse_reg <= (count_in != count_prev_reg);
            if (wrap) begin
                blink_phase_reg <= ~blink_phase_reg;
            end
            led_reg <= led_next;
        end
    end

    assign led        = led_reg;
    assign mode       = mode_reg;
    assign step_pulse = step_pulse_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Directed bench for led_pattern_ctrl (DEBOUNCE_CYCLES = 16). Inputs are
// driven 1 ns after the rising edge and outputs sampled at the same point.
// ---------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] count_in;
    logic       mode_btn;
    logic       pause;
    logic [7:0] led;
    logic [1:0] mode;
    logic       step_pulse;

    int checks;
    int errors;

    led_pattern_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .mode_btn   (mode_btn),
        .pause      (pause),
        .led        (led),
        .mode       (mode),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end else begin
            $display("chk  %s = %h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press();
        mode_btn = 1'b1;
        tick(25);
        mode_btn = 1'b0;
        tick(25);
    endtask

    logic [2:0] seq [8];
    logic       blink_m;
    logic [2:0] prev_m;
    logic [7:0] exp_led;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        count_in = 3'd0;
        mode_btn = 1'b0;
        pause    = 1'b0;
        seq = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

        // Reset state
        tick(2);
        chk("rst_led", led, 8'h00);
        chk("rst_mode", {6'd0, mode}, 8'd0);
        chk("rst_step", {7'd0, step_pulse}, 8'd0);
        reset = 1'b0;

        // SINGLE sweep
        for (int i = 0; i < 8; i++) begin
            count_in = seq[i];
            tick(1);
            chk($sformatf("single_led_%0d", seq[i]), led, 8'h01 << seq[i]);
            chk($sformatf("single_step_%0d", i), {7'd0, step_pulse}, (i != 0) ? 8'd1 : 8'd0);
        end
        tick(1);
        chk("step_idle", {7'd0, step_pulse}, 8'd0);

        // Debounce: bounce every 3 clocks, then a solid hold
        do_reset();
        for (int k = 0; k < 40; k++) begin
            mode_btn = ((k / 3) % 2 == 0);
            tick(1);
        end
        chk("db_bounce_mode", {6'd0, mode}, 8'd0);
        mode_btn = 1'b1;
        tick(30);
        chk("db_hold_mode", {6'd0, mode}, 8'd1);
        for (int k = 0; k < 20; k++) begin
            mode_btn = ((k / 3) % 2 != 0);
            tick(1);
        end
        mode_btn = 1'b0;
        tick(30);
        chk("db_release_mode", {6'd0, mode}, 8'd1);

        // Mode cycle with INVERT/FILL patterns at count_in = 3
        do_reset();
        count_in = 3'd3;
        press();
        chk("cyc_mode1", {6'd0, mode}, 8'd1);
        chk("invert_led", led, 8'hF7);
        press();
        chk("cyc_mode2", {6'd0, mode}, 8'd2);
        chk("fill_led", led, 8'hF8);
        press();
        chk("cyc_mode3", {6'd0, mode}, 8'd3);
        press();
        chk("cyc_mode0", {6'd0, mode}, 8'd0);
        chk("single_led3", led, 8'h08);

        // BLINK over two counter periods
        count_in = 3'd0;
        do_reset();
        press();
        press();
        press();
        chk("blink_mode", {6'd0, mode}, 8'd3);
        chk("blink_start", led, 8'h00);
        blink_m = 1'b0;
        prev_m  = 3'd0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i <= 8; i++) begin
                count_in = seq[i % 8];
                exp_led  = blink_m ? 8'hFF : 8'h00;
                if (prev_m == 3'd0 && count_in == 3'd7) blink_m = ~blink_m;
                prev_m = count_in;
                tick(1);
                chk($sformatf("blink_p%0d_s%0d", p, i), led, exp_led);
            end
        end
        tick(1);
        chk("blink_end", led, 8'h00);

        // Pause freezes led, step_pulse keeps running
        count_in = 3'd0;
        do_reset();
        count_in = 3'd4;
        tick(1);
        chk("pause_pre", led, 8'h10);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            count_in = 3'(3 - i);
            tick(1);
            chk($sformatf("pause_led_%0d", i), led, 8'h10);
            chk($sformatf("pause_step_%0d", i), {7'd0, step_pulse}, 8'd1);
        end
        pause = 1'b0;
        tick(1);
        chk("unpause_led", led, 8'h80);

        // Async reset between edges in FILL mode
        count_in = 3'd0;
        do_reset();
        press();
        press();
        chk("fill_ff", led, 8'hFF);
        chk("fill_mode", {6'd0, mode}, 8'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_led", led, 8'h00);
        chk("async_mode", {6'd0, mode}, 8'd0);

        // Button held across reset release advances mode once
        mode_btn = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(30);
        chk("held_mode", {6'd0, mode}, 8'd1);
        mode_btn = 1'b0;
        tick(25);
        chk("held_release", {6'd0, mode}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
